// File: rtl/q1_pkg.sv
// q1_pkg: shared types and constants for the q1 test-vector sequencer
package q1_pkg;
  localparam int Q1_DEPTH_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
    logic [1:0] op;
  } vec_t;
endpackage

// File: rtl/q1_sequencer_if.sv
// q1_sequencer_if: vector load, q1 drive/return and result signals of the sequencer
interface q1_sequencer_if import q1_pkg::*; #(
  parameter int DEPTH = Q1_DEPTH_DEFAULT
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          vec_valid;
  logic          vec_ready;
  logic [7:0]    vec_input;
  logic [1:0]    vec_sel;
  logic [1:0]    vec_op;
  logic          start;
  logic [7:0]    MyInput;
  logic [1:0]    MyConstantSelect;
  logic [1:0]    MyOperation;
  logic [7:0]    MyOutput;
  logic          MyStatus;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_status;
  logic          busy;
  logic          done;
  logic [CW-1:0] status_count;
  logic [7:0]    checksum;
  modport master (
    output vec_valid, vec_input, vec_sel, vec_op, start, MyOutput, MyStatus,
    input  vec_ready, MyInput, MyConstantSelect, MyOperation, res_valid, res_data,
    input  res_status, busy, done, status_count, checksum
  );
  modport slave (
    input  vec_valid, vec_input, vec_sel, vec_op, start, MyOutput, MyStatus,
    output vec_ready, MyInput, MyConstantSelect, MyOperation, res_valid, res_data,
    output res_status, busy, done, status_count, checksum
  );
endinterface

// File: rtl/q1_vec_fifo.sv
// q1_vec_fifo: vector buffer with wrapping pointers and a saturating fill count
module q1_vec_fifo import q1_pkg::*; #(
  parameter int DEPTH = Q1_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  vec_t        i_data,
  input  logic        i_pop,
  output vec_t        o_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);
  vec_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/q1_sequencer.sv
// q1_sequencer: plays buffered vectors through the q1 block and accumulates result statistics
module q1_sequencer import q1_pkg::*; #(
  parameter int DEPTH = Q1_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  q1_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t      r_state;
  vec_t        w_in, w_head;
  logic        w_full, w_empty, w_push, w_pop, w_last;
  logic [AW:0] w_count;
  logic [7:0]  r_my_input, r_res_data, r_checksum;
  logic [1:0]  r_my_sel, r_my_op;
  logic        r_res_valid, r_res_status, r_busy, r_done;
  logic [AW:0] r_status_count;
  assign w_in   = {bus.vec_input, bus.vec_sel, bus.vec_op};
  assign w_push = bus.vec_valid && bus.vec_ready;
  assign w_pop  = r_state == SAMPLE;
  assign w_last = w_count == (AW+1)'(1);
  // start blocks loading so a vector can never sneak into a run already being launched
  assign bus.vec_ready        = r_state == IDLE && !w_full && !bus.start;
  assign bus.MyInput          = r_my_input;
  assign bus.MyConstantSelect = r_my_sel;
  assign bus.MyOperation      = r_my_op;
  assign bus.res_valid        = r_res_valid;
  assign bus.res_data         = r_res_data;
  assign bus.res_status       = r_res_status;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.status_count     = r_status_count;
  assign bus.checksum         = r_checksum;
  q1_vec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state        <= IDLE;
      r_my_input     <= '0;
      r_my_sel       <= '0;
      r_my_op        <= '0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_status   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_status_count <= '0;
      r_checksum     <= '0;
    end else begin
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_status_count <= '0;
          r_checksum     <= '0;
          r_busy         <= 1'b1;
          r_done         <= w_empty;
          r_state        <= w_empty ? FINISH : DRIVE;
        end
        DRIVE: begin
          r_my_input <= w_head.data;
          r_my_sel   <= w_head.sel;
          r_my_op    <= w_head.op;
          r_state    <= SAMPLE;
        end
        SAMPLE: begin
          r_res_data     <= bus.MyOutput;
          r_res_status   <= bus.MyStatus;
          r_res_valid    <= 1'b1;
          r_checksum     <= r_checksum ^ bus.MyOutput;
          r_status_count <= r_status_count + (AW+1)'(bus.MyStatus);
          r_done         <= w_last;
          r_state        <= w_last ? FINISH : DRIVE;
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_q1_sequencer.sv
// tb_q1_sequencer: directed table-driven checks of the q1 sequencer against a small q1 model
module tb_q1_sequencer;
  import q1_pkg::*;
  typedef struct {
    logic [7:0] din;
    logic [1:0] sel;
    logic [1:0] op;
    logic [7:0] exp_data;
    logic       exp_st;
  } vec_rec_t;
  logic clk, rst_n;
  int errors, checks;
  vec_rec_t tbl [10];
  logic [7:0] w_k, w_res;
  q1_sequencer_if #(.DEPTH(4)) bus ();
  q1_sequencer #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  // q1 model: op0/op1 add, op2 xor, op3 subtract a selected constant; status is result bit 1
  assign w_k = bus.MyConstantSelect == 2'd0 ? 8'h10 : bus.MyConstantSelect == 2'd1 ? 8'h20 :
               bus.MyConstantSelect == 2'd2 ? 8'h30 : 8'h03;
  assign w_res = bus.MyOperation == 2'd2 ? bus.MyInput ^ w_k :
                 bus.MyOperation == 2'd3 ? bus.MyInput - w_k : bus.MyInput + w_k;
  assign bus.MyOutput = w_res;
  assign bus.MyStatus = w_res[1];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic load(input int i);
    chk("ready_before_load", 32'(bus.vec_ready), 1);
    bus.vec_valid = 1'b1;
    bus.vec_input = tbl[i].din;
    bus.vec_sel   = tbl[i].sel;
    bus.vec_op    = tbl[i].op;
    step();
    bus.vec_valid = 1'b0;
  endtask
  task automatic chk_idle_zero(input string nm);
    chk({nm, "_ready"}, 32'(bus.vec_ready), 1);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
    chk({nm, "_done"}, 32'(bus.done), 0);
    chk({nm, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({nm, "_myinput"}, 32'(bus.MyInput), 0);
    chk({nm, "_outs"}, {bus.MyConstantSelect, bus.MyOperation, bus.res_data, bus.res_status,
                        bus.status_count, bus.checksum}, 0);
  endtask
  task automatic run_expect(input int first, input int n, input int exp_cnt, input int exp_cs,
                            input bit hold);
    int k;
    int done_cyc;
    k = 0;
    done_cyc = -1;
    bus.start = 1'b1;
    step();
    bus.start = hold;
    chk("busy_after_start", 32'(bus.busy), 1);
    for (int c = 1; c <= 2 * n + 4; c++) begin
      if (bus.res_valid) begin
        if (k < n) begin
          chk("res_data", 32'(bus.res_data), 32'(tbl[first + k].exp_data));
          chk("res_status", 32'(bus.res_status), 32'(tbl[first + k].exp_st));
          chk("res_cycle", c, 2 * k + 3);
          chk("drive_input", 32'(bus.MyInput), 32'(tbl[first + k].din));
        end else chk("extra_res", k, n);
        k++;
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    bus.start = 1'b0;
    chk("done_cycle", done_cyc, 2 * n + 1);
    chk("res_count", k, n);
    chk("status_count", 32'(bus.status_count), exp_cnt);
    chk("checksum", 32'(bus.checksum), exp_cs);
    step();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_end", 32'(bus.busy), 0);
    chk("ready_end", 32'(bus.vec_ready), 1);
  endtask
  initial begin
    errors = 0;
    checks = 0;
    tbl[0] = '{8'h00, 2'd0, 2'd0, 8'h10, 1'b0};
    tbl[1] = '{8'h07, 2'd3, 2'd1, 8'h0A, 1'b1};
    tbl[2] = '{8'h03, 2'd1, 2'd2, 8'h23, 1'b1};
    tbl[3] = '{8'h03, 2'd2, 2'd3, 8'hD3, 1'b1};
    tbl[4] = '{8'h01, 2'd0, 2'd0, 8'h11, 1'b0};
    tbl[5] = '{8'h02, 2'd1, 2'd1, 8'h22, 1'b1};
    tbl[6] = '{8'h05, 2'd2, 2'd2, 8'h35, 1'b0};
    tbl[7] = '{8'h40, 2'd3, 2'd3, 8'h3D, 1'b0};
    tbl[8] = '{8'h12, 2'd0, 2'd2, 8'h02, 1'b1};
    tbl[9] = '{8'h80, 2'd1, 2'd0, 8'hA0, 1'b0};
    rst_n = 1'b0;
    bus.vec_valid = 1'b0;
    bus.vec_input = '0;
    bus.vec_sel   = '0;
    bus.vec_op    = '0;
    bus.start     = 1'b0;
    step();
    step();
    chk_idle_zero("reset");
    rst_n = 1'b1;
    step();
    run_expect(0, 0, 0, 0, 1'b0);
    load(1);
    run_expect(1, 1, 1, 8'h0A, 1'b0);
    for (int i = 0; i < 4; i++) load(i);
    chk("ready_when_full", 32'(bus.vec_ready), 0);
    bus.vec_valid = 1'b1;
    bus.vec_input = 8'hFF;
    bus.vec_sel   = 2'd3;
    bus.vec_op    = 2'd3;
    step();
    bus.vec_valid = 1'b0;
    run_expect(0, 4, 3, 8'hEA, 1'b0);
    for (int i = 4; i < 7; i++) load(i);
    run_expect(4, 3, 1, 8'h06, 1'b0);
    for (int i = 7; i < 10; i++) load(i);
    run_expect(7, 3, 1, 8'h9F, 1'b0);
    bus.start     = 1'b1;
    bus.vec_valid = 1'b1;
    bus.vec_input = tbl[0].din;
    bus.vec_sel   = tbl[0].sel;
    bus.vec_op    = tbl[0].op;
    #1;
    chk("collision_ready", 32'(bus.vec_ready), 0);
    step();
    bus.start     = 1'b0;
    bus.vec_valid = 1'b0;
    chk("collision_empty_done", 32'(bus.done), 1);
    step();
    run_expect(0, 0, 0, 0, 1'b0);
    load(4);
    load(5);
    run_expect(4, 2, 1, 8'h33, 1'b1);
    load(7);
    load(8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midrun_reset");
    step();
    chk_idle_zero("midrun_reset_edge");
    rst_n = 1'b1;
    step();
    run_expect(0, 0, 0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/q1_sequencer.md
Q1_SEQUENCER -- requirements
Module: q1_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, sets the vector buffer entry count; a power of two, 2..16.
REQ-002 clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 vec_valid  in  1  load request for one test vector.
REQ-005 vec_ready  out  1  buffer can accept a vector this cycle.
REQ-006 vec_input  in  8  operand to drive onto MyInput.
REQ-007 vec_sel  in  2  value to drive onto MyConstantSelect.
REQ-008 vec_op  in  2  value to drive onto MyOperation.
REQ-009 start  in  1  begin a run over all buffered vectors.
REQ-010 MyInput  out  8  operand driven to the q1 block.
REQ-011 MyConstantSelect  out  2  constant select driven to the q1 block.
REQ-012 MyOperation  out  2  operation code driven to the q1 block.
REQ-013 MyOutput  in  8  q1 result (combinational in q1).
REQ-014 MyStatus  in  1  q1 status flag.
REQ-015 res_valid  out  1  one-cycle pulse; res_data and res_status are valid.
REQ-016 res_data  out  8  captured MyOutput.
REQ-017 res_status  out  1  captured MyStatus.
REQ-018 busy  out  1  high from the cycle after start is accepted until done.
REQ-019 done  out  1  one-cycle pulse at the end of a run.
REQ-020 status_count  out  $clog2(DEPTH)+1  count of vectors with MyStatus=1 in the last run.
REQ-021 checksum  out  8  XOR of all res_data values in the last run.

Function
REQ-022 FSM states: IDLE, DRIVE, SAMPLE, FINISH.
REQ-023 IDLE: vec_ready = (buffer not full).
- A load occurs when vec_valid && vec_ready.
- A load writes at the write pointer and increments the fill count.
REQ-024 IDLE with start=1 behaves as follows:
- Clears status_count and checksum.
- Goes to DRIVE if the buffer is non-empty; otherwise goes to FINISH.
- start has priority; a simultaneous load is not accepted because vec_ready=0 whenever start=1.
REQ-025 DRIVE: presents the head entry on MyInput/MyConstantSelect/MyOperation as registered outputs; next state is SAMPLE.
REQ-026 SAMPLE behaves as follows:
- Captures MyOutput/MyStatus into res_data/res_status.
- Pulses res_valid the next cycle.
- Updates checksum (XOR) and status_count (+MyStatus).
- Pops the head entry.
- Goes to DRIVE if entries remain; otherwise goes to FINISH.
REQ-027 Per-vector latency: 2 cycles; res_valid asserts 2 cycles after the DRIVE entry edge. A run of N vectors takes 2N+1 cycles from start to done.
REQ-028 FINISH: pulses done for one cycle; returns to IDLE with the buffer empty.
REQ-029 Drive outputs hold their last driven value outside DRIVE/SAMPLE.
REQ-030 vec_ready=0 and start is ignored in DRIVE, SAMPLE and FINISH.
REQ-031 Read and write pointers wrap modulo DEPTH; fill count saturates at DEPTH (vec_ready=0 when full).
REQ-032 status_count and checksum hold until the next accepted start.

Reset
REQ-033 rst_n low immediately forces:
- State = IDLE; buffer empty; pointers = 0.
- All outputs 0, except vec_ready = 1.
REQ-034 Reset mid-run aborts the run without a done pulse; buffered vectors are discarded.

Structure
REQ-035 Shared package q1_pkg holds:
- typedef of the state enum.
- typedef of the vector struct {input[7:0], sel[1:0], op[1:0]}.
- Constant Q1_DEPTH_DEFAULT=4.
REQ-036 The buffer is one sub-module, q1_vec_fifo, holding the storage, pointers and fill count; the FSM stays in q1_sequencer.

Verification
REQ-037 Reset: rst_n=0 mid-DRIVE -> next edge shows state IDLE, all outputs 0, vec_ready=1, no done pulse.
REQ-038 Empty run: start with empty buffer -> done 1 cycle later, status_count=0, checksum=0, no res_valid.
REQ-039 Single vector (0x07,3,1) with q1 model returning 0x0A/status 1 -> res_valid 2 cycles after DRIVE with res_data=0x0A, res_status=1; done pulse; status_count=1, checksum=0x0A.
REQ-040 Full buffer: load 4 vectors (0x00,0,0), (0x07,3,1), (0x03,1,2), (0x03,2,3):
- vec_ready=0 after the 4th load; a 5th vec_valid is not accepted.
- Run: 4 res_valid pulses in load order; done at cycle 9 after start.
REQ-041 Wrap-around: two back-to-back runs of 3 vectors each -> the second run drives the correct vectors across the pointer wrap; checksum reflects only the second run.
REQ-042 Collision: start and vec_valid in the same IDLE cycle -> vector not loaded; start is ignored while busy=1.
